timer_sequencer: RTL and testbench

- APB master controller that programs and runs the 8-bit timer (TDR 0x00, TCR 0x01, TSR 0x02) from a simple command interface.
- Sequence: clear stale flags, load the reload value, start counting, poll TSR for overflow/underflow, report and clear the event, then re-arm (periodic) or stop (one-shot).
- Sits between the system controller and the timer's APB slave port; replaces hand-sequenced CPU register writes.

---
 rtl/timer_pkg.sv | 36 +++
 rtl/timer_sequencer_if.sv | 24 ++
 rtl/apb_master_xfer.sv | 62 ++++++
 rtl/timer_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_timer_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared constants for the timer sequencer.
//   - default APB register addresses of the 8-bit timer (TDR/TCR/TSR)
//   - TCR / TSR bit positions
//   - sequencer FSM state encoding
package timer_pkg;

   localparam logic [7:0] DEF_ADDR_TDR = 8'h00;
   localparam logic [7:0] DEF_ADDR_TCR = 8'h01;
   localparam logic [7:0] DEF_ADDR_TSR = 8'h02;

   // TCR fields
   localparam int TCR_LOAD     = 7;
   localparam int TCR_DOWN     = 5;
   localparam int TCR_EN       = 4;
   localparam int TCR_CKS_MSB  = 1;
   localparam int TCR_CKS_LSB  = 0;

   // TSR flags
   localparam int TSR_OVF = 0;
   localparam int TSR_UDF = 1;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RD_TSR,
      ST_CLR_TSR,
      ST_WR_TDR,
      ST_LOAD,
      ST_RUN,
      ST_GAP,
      ST_POLL,
      ST_EVT,
      ST_ACK,
      ST_HALT
   } seq_state_e;

endpackage

// File: rtl/timer_sequencer_if.sv
// timer_sequencer_if: APB bus between the sequencer (master) and the
// timer register block (slave).
//   paddr/pwdata/pwrite/psel/penable : master -> slave
//   prdata/pready/pslverr            : slave  -> master
interface timer_sequencer_if;
   logic [7:0] paddr;
   logic [7:0] pwdata;
   logic       pwrite;
   logic       psel;
   logic       penable;
   logic [7:0] prdata;
   logic       pready;
   logic       pslverr;

   modport master (
      output paddr, pwdata, pwrite, psel, penable,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  paddr, pwdata, pwrite, psel, penable,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_master_xfer.sv
// apb_master_xfer: runs one APB transfer per request.
//   i_req/i_wr/i_addr/i_wdata : transfer request (level, sampled when idle)
//   o_done                    : one-cycle pulse after the transfer completes
//   o_rdata/o_slverr          : read data and error, valid with o_done
//   o_p* / i_p*               : registered APB master signals
module apb_master_xfer (
   input  logic       pclk,
   input  logic       preset,
   input  logic       i_req,
   input  logic       i_wr,
   input  logic [7:0] i_addr,
   input  logic [7:0] i_wdata,
   output logic       o_done,
   output logic [7:0] o_rdata,
   output logic       o_slverr,
   output logic       o_psel,
   output logic       o_penable,
   output logic       o_pwrite,
   output logic [7:0] o_paddr,
   output logic [7:0] o_pwdata,
   input  logic [7:0] i_prdata,
   input  logic       i_pready,
   input  logic       i_pslverr
);

   always_ff @(posedge pclk) begin
      if (preset) begin
         o_psel    <= 1'b0;
         o_penable <= 1'b0;
         o_pwrite  <= 1'b0;
         o_paddr   <= 8'h00;
         o_pwdata  <= 8'h00;
         o_done    <= 1'b0;
         o_rdata   <= 8'h00;
         o_slverr  <= 1'b0;
      end else begin
         o_done <= 1'b0;
         if (!o_psel) begin
            // The requester still holds i_req during the done cycle while it
            // moves on; ignoring it then avoids repeating the finished transfer.
            if (i_req && !o_done) begin
               o_psel   <= 1'b1;
               o_pwrite <= i_wr;
               o_paddr  <= i_addr;
               o_pwdata <= i_wdata;
            end
         end else if (!o_penable) begin
            o_penable <= 1'b1;
         end else if (i_pready) begin
            o_psel    <= 1'b0;
            o_penable <= 1'b0;
            o_pwrite  <= 1'b0;
            o_paddr   <= 8'h00;
            o_pwdata  <= 8'h00;
            o_done    <= 1'b1;
            o_rdata   <= i_prdata;
            o_slverr  <= i_pslverr;
         end
      end
   end

endmodule

// File: rtl/timer_sequencer.sv
// timer_sequencer: programs and runs the 8-bit timer over APB.
//   pclk/preset          : clock, synchronous active-high reset
//   cmd_*                : start command (valid/ready handshake, latched)
//   stop_req             : level request to halt the timer
//   apb                  : APB master port
//   evt_pulse/evt_udf    : one pulse per detected overflow/underflow
//   busy/err             : activity and sticky bus-error status
module timer_sequencer
   import timer_pkg::*;
#(
   parameter int         POLL_GAP = 16,
   parameter logic [7:0] ADDR_TDR = DEF_ADDR_TDR,
   parameter logic [7:0] ADDR_TCR = DEF_ADDR_TCR,
   parameter logic [7:0] ADDR_TSR = DEF_ADDR_TSR
) (
   input  logic               pclk,
   input  logic               preset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [7:0]         cmd_reload,
   input  logic               cmd_down,
   input  logic [1:0]         cmd_cks,
   input  logic               cmd_periodic,
   input  logic               stop_req,
   timer_sequencer_if.master  apb,
   output logic               evt_pulse,
   output logic               evt_udf,
   output logic               busy,
   output logic               err
);

   localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

   seq_state_e r_state;
   logic [7:0] r_reload;
   logic       r_down;
   logic [1:0] r_cks;
   logic       r_periodic;
   logic [7:0] r_gap_cnt;
   logic       r_cmd_ready, r_busy, r_evt_pulse, r_evt_udf, r_err;

   logic       w_req, w_wr, w_done, w_slverr, w_hit;
   logic [7:0] w_addr, w_wdata, w_rdata;

   assign cmd_ready = r_cmd_ready;
   assign busy      = r_busy;
   assign evt_pulse = r_evt_pulse;
   assign evt_udf   = r_evt_udf;
   assign err       = r_err;

   // Transfer request decoded from the state; GAP/EVT/IDLE issue nothing.
   always_comb begin
      w_req   = 1'b0;
      w_wr    = 1'b0;
      w_addr  = ADDR_TSR;
      w_wdata = 8'h00;
      case (r_state)
         ST_RD_TSR, ST_POLL: w_req = 1'b1;
         ST_CLR_TSR, ST_ACK: begin
            w_req = 1'b1;
            w_wr  = 1'b1;
         end
         ST_WR_TDR: begin
            w_req   = 1'b1;
            w_wr    = 1'b1;
            w_addr  = ADDR_TDR;
            w_wdata = r_reload;
         end
         ST_LOAD: begin
            w_req             = 1'b1;
            w_wr              = 1'b1;
            w_addr            = ADDR_TCR;
            w_wdata[TCR_LOAD] = 1'b1;
         end
         ST_RUN: begin
            w_req                              = 1'b1;
            w_wr                               = 1'b1;
            w_addr                             = ADDR_TCR;
            w_wdata[TCR_DOWN]                  = r_down;
            w_wdata[TCR_EN]                    = 1'b1;
            w_wdata[TCR_CKS_MSB:TCR_CKS_LSB]   = r_cks;
         end
         ST_HALT: begin
            w_req  = 1'b1;
            w_wr   = 1'b1;
            w_addr = ADDR_TCR;
         end
         default: ;
      endcase
   end

   // Only the flag matching the count direction counts as an event.
   assign w_hit = r_down ? w_rdata[TSR_UDF] : w_rdata[TSR_OVF];

   apb_master_xfer u_xfer (
      .pclk      (pclk),
      .preset    (preset),
      .i_req     (w_req),
      .i_wr      (w_wr),
      .i_addr    (w_addr),
      .i_wdata   (w_wdata),
      .o_done    (w_done),
      .o_rdata   (w_rdata),
      .o_slverr  (w_slverr),
      .o_psel    (apb.psel),
      .o_penable (apb.penable),
      .o_pwrite  (apb.pwrite),
      .o_paddr   (apb.paddr),
      .o_pwdata  (apb.pwdata),
      .i_prdata  (apb.prdata),
      .i_pready  (apb.pready),
      .i_pslverr (apb.pslverr)
   );

   always_ff @(posedge pclk) begin
      if (preset) begin
         r_state     <= ST_IDLE;
         r_reload    <= 8'h00;
         r_down      <= 1'b0;
         r_cks       <= 2'b00;
         r_periodic  <= 1'b0;
         r_gap_cnt   <= 8'h00;
         r_cmd_ready <= 1'b1;
         r_busy      <= 1'b0;
         r_evt_pulse <= 1'b0;
         r_evt_udf   <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_evt_pulse <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_reload    <= cmd_reload;
                  r_down      <= cmd_down;
                  r_cks       <= cmd_cks;
                  r_periodic  <= cmd_periodic;
                  r_err       <= 1'b0;
                  r_cmd_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= ST_RD_TSR;
               end
            end
            ST_GAP: begin
               if (stop_req) begin
                  r_state <= ST_HALT;
               end else if (r_gap_cnt == GAP_LAST) begin
                  r_gap_cnt <= 8'h00;
                  r_state   <= ST_POLL;
               end else begin
                  r_gap_cnt <= r_gap_cnt + 8'h01;
               end
            end
            ST_EVT: r_state <= stop_req ? ST_HALT : ST_ACK;
            default: begin
               // Every other state owns one transfer; decide only once it ends.
               if (w_done) begin
                  if (w_slverr) r_err <= 1'b1;
                  if (r_state == ST_HALT) begin
                     // A failed HALT write still ends the run.
                     r_state     <= ST_IDLE;
                     r_cmd_ready <= 1'b1;
                     r_busy      <= 1'b0;
                  end else if (w_slverr || stop_req) begin
                     r_state <= ST_HALT;
                  end else begin
                     case (r_state)
                        ST_RD_TSR:  r_state <= (w_rdata != 8'h00) ? ST_CLR_TSR : ST_WR_TDR;
                        ST_CLR_TSR: r_state <= ST_WR_TDR;
                        ST_WR_TDR:  r_state <= ST_LOAD;
                        ST_LOAD:    r_state <= ST_RUN;
                        ST_RUN: begin
                           r_gap_cnt <= 8'h00;
                           r_state   <= ST_GAP;
                        end
                        ST_POLL: begin
                           if (w_hit) begin
                              r_evt_pulse <= 1'b1;
                              r_evt_udf   <= r_down;
                              r_state     <= ST_EVT;
                           end else begin
                              r_gap_cnt <= 8'h00;
                              r_state   <= ST_GAP;
                           end
                        end
                        ST_ACK:  r_state <= r_periodic ? ST_LOAD : ST_HALT;
                        default: r_state <= ST_HALT;
                     endcase
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_timer_sequencer.sv
// tb_timer_sequencer: bench for timer_sequencer. A scripted APB slave logs
// every transfer; expected transfer lists are built from the documented
// register sequence and compared entry by entry.
module tb_timer_sequencer;

   localparam logic [7:0] A_TDR = 8'h00;
   localparam logic [7:0] A_TCR = 8'h01;
   localparam logic [7:0] A_TSR = 8'h02;

   typedef struct packed {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] data;
      logic [7:0] len;
   } xfer_t;

   typedef struct {
      logic [7:0] reload;
      bit         down;
      logic [1:0] cks;
      logic [7:0] stale;
      int         ws;
      logic [7:0] exp_run;
      bit         exp_udf;
   } vec_t;

   logic       pclk = 1'b0;
   logic       preset;
   logic       cmd_valid, cmd_ready, cmd_down, cmd_periodic, stop_req;
   logic [7:0] cmd_reload;
   logic [1:0] cmd_cks;
   logic       evt_pulse, evt_udf, busy, err;

   timer_sequencer_if bus ();

   timer_sequencer dut (
      .pclk        (pclk),
      .preset      (preset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_reload  (cmd_reload),
      .cmd_down    (cmd_down),
      .cmd_cks     (cmd_cks),
      .cmd_periodic(cmd_periodic),
      .stop_req    (stop_req),
      .apb         (bus),
      .evt_pulse   (evt_pulse),
      .evt_udf     (evt_udf),
      .busy        (busy),
      .err         (err)
   );

   always #5 pclk = ~pclk;

   int         ntests = 0, nfail = 0;
   int         ws_cfg = 0, err_at = -1, stop_at = -1, stop_dly = 0, stop_cnt = 0;
   int         n_wide = 0;
   xfer_t      log_q[$], exp_q[$];
   logic [7:0] tsr_q[$], quiet_q[$];
   bit         evt_q[$];
   vec_t       vt[5];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
      ntests++;
      if (got !== expv) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", nm, got, expv);
      end
   endtask

   // Scripted APB slave: wait states, TSR read script, error/stop injection.
   initial begin
      int ws_cnt, xlen;
      logic [7:0] rd;
      xfer_t e;
      ws_cnt = 0; xlen = 0;
      bus.pready = 1'b0; bus.prdata = 8'h00; bus.pslverr = 1'b0;
      forever begin
         @(negedge pclk);
         if (stop_cnt > 0) begin
            stop_cnt--;
            if (stop_cnt == 0) stop_req = 1'b1;
         end
         if (bus.psel && !bus.penable) begin
            xlen = 1; ws_cnt = 0; bus.pready = 1'b0; bus.pslverr = 1'b0;
         end else if (bus.psel && bus.penable) begin
            xlen++;
            if (ws_cnt < ws_cfg) begin
               ws_cnt++;
               bus.pready = 1'b0;
            end else begin
               rd = 8'h00;
               if (!bus.pwrite && bus.paddr == A_TSR && tsr_q.size() > 0) rd = tsr_q.pop_front();
               bus.pready  = 1'b1;
               bus.prdata  = rd;
               bus.pslverr = (log_q.size() == err_at);
               e.wr   = bus.pwrite;
               e.addr = bus.paddr;
               e.data = bus.pwrite ? bus.pwdata : rd;
               e.len  = 8'(xlen);
               log_q.push_back(e);
               if (log_q.size() == stop_at) begin
                  if (stop_dly == 0) stop_req = 1'b1;
                  else stop_cnt = stop_dly;
               end
            end
         end else begin
            bus.pready = 1'b0; bus.pslverr = 1'b0; ws_cnt = 0;
         end
      end
   end

   // Event monitor.
   initial begin
      bit prev;
      prev = 1'b0;
      forever begin
         @(negedge pclk);
         if (evt_pulse === 1'b1) begin
            evt_q.push_back(evt_udf);
            if (prev) n_wide++;
         end
         prev = (evt_pulse === 1'b1);
      end
   end

   task automatic prepare(input int ws);
      log_q.delete(); exp_q.delete(); tsr_q.delete(); evt_q.delete();
      n_wide = 0; ws_cfg = ws; err_at = -1; stop_at = -1; stop_dly = 0; stop_cnt = 0;
      stop_req = 1'b0;
   endtask

   task automatic exp_push(input logic wr, input logic [7:0] a, input logic [7:0] d);
      xfer_t e;
      e.wr = wr; e.addr = a; e.data = d; e.len = 8'(2 + ws_cfg);
      exp_q.push_back(e);
   endtask

   // Reference for a one-shot run: stale check, program, poll until the
   // event value, acknowledge, halt. Also scripts the TSR read values.
   task automatic setup_oneshot(input logic [7:0] rl, input logic [7:0] run,
                                input logic [7:0] stale, input logic [7:0] ev);
      tsr_q.push_back(stale);
      exp_push(1'b0, A_TSR, stale);
      if (stale != 8'h00) exp_push(1'b1, A_TSR, 8'h00);
      exp_push(1'b1, A_TDR, rl);
      exp_push(1'b1, A_TCR, 8'h80);
      exp_push(1'b1, A_TCR, run);
      foreach (quiet_q[i]) begin
         tsr_q.push_back(quiet_q[i]);
         exp_push(1'b0, A_TSR, quiet_q[i]);
      end
      tsr_q.push_back(ev);
      exp_push(1'b0, A_TSR, ev);
      exp_push(1'b1, A_TSR, 8'h00);
      exp_push(1'b1, A_TCR, 8'h00);
   endtask

   task automatic start_cmd(input string tag, input logic [7:0] rl, input bit dn,
                            input logic [1:0] ck, input bit per);
      int t;
      t = 0;
      while (cmd_ready !== 1'b1 && t < 200) begin @(negedge pclk); t++; end
      chk({tag, " ready"}, cmd_ready, 1'b1);
      cmd_reload = rl; cmd_down = dn; cmd_cks = ck; cmd_periodic = per;
      cmd_valid = 1'b1;
      @(negedge pclk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int t;
      t = 0;
      while (cmd_ready !== 1'b1 && t < 5000) begin @(negedge pclk); t++; end
      chk({tag, " done"}, cmd_ready, 1'b1);
      chk({tag, " busy"}, busy, 1'b0);
   endtask

   task automatic check_log(input string tag);
      int n;
      chk({tag, " nxfer"}, log_q.size(), exp_q.size());
      n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s xfer%0d", tag, i), log_q[i], exp_q[i]);
   endtask

   task automatic check_evt(input string tag, input int n, input bit udf);
      chk({tag, " nevt"}, evt_q.size(), n);
      foreach (evt_q[i]) chk($sformatf("%s udf%0d", tag, i), evt_q[i], udf);
      chk({tag, " pulse width"}, n_wide, 0);
   endtask

   initial begin
      vt[0] = '{8'h64, 1'b1, 2'b10, 8'h00, 0, 8'h32, 1'b1};
      vt[1] = '{8'h64, 1'b1, 2'b10, 8'h01, 0, 8'h32, 1'b1};
      vt[2] = '{8'h79, 1'b0, 2'b00, 8'h00, 3, 8'h10, 1'b0};
      vt[3] = '{8'hA5, 1'b0, 2'b11, 8'h02, 1, 8'h13, 1'b0};
      vt[4] = '{8'h00, 1'b1, 2'b01, 8'h03, 2, 8'h31, 1'b1};

      cmd_valid = 1'b0; cmd_reload = 8'h00; cmd_down = 1'b0; cmd_cks = 2'b00;
      cmd_periodic = 1'b0; stop_req = 1'b0; preset = 1'b1;
      repeat (3) @(negedge pclk);
      chk("rst cmd_ready", cmd_ready, 1'b1);
      chk("rst busy", busy, 1'b0);
      chk("rst err", err, 1'b0);
      chk("rst evt_pulse", evt_pulse, 1'b0);
      chk("rst evt_udf", evt_udf, 1'b0);
      chk("rst psel/penable/pwrite", {bus.psel, bus.penable, bus.pwrite}, 3'b000);
      chk("rst paddr/pwdata", {bus.paddr, bus.pwdata}, 16'h0000);
      preset = 1'b0;
      @(negedge pclk);

      // Table: one-shot runs, stale flags, wait states.
      foreach (vt[i]) begin
         prepare(vt[i].ws);
         quiet_q.delete();
         quiet_q.push_back(8'h00);
         setup_oneshot(vt[i].reload, vt[i].exp_run, vt[i].stale, vt[i].down ? 8'h02 : 8'h01);
         start_cmd($sformatf("vec%0d", i), vt[i].reload, vt[i].down, vt[i].cks, 1'b0);
         wait_idle($sformatf("vec%0d", i));
         check_log($sformatf("vec%0d", i));
         check_evt($sformatf("vec%0d", i), 1, vt[i].exp_udf);
      end

      // Periodic up-count: three events, then stop right after the third re-arm.
      prepare(0);
      tsr_q.push_back(8'h00);
      exp_push(1'b0, A_TSR, 8'h00);
      exp_push(1'b1, A_TDR, 8'h79);
      exp_push(1'b1, A_TCR, 8'h80);
      exp_push(1'b1, A_TCR, 8'h10);
      for (int k = 0; k < 3; k++) begin
         tsr_q.push_back(8'h01);
         exp_push(1'b0, A_TSR, 8'h01);
         exp_push(1'b1, A_TSR, 8'h00);
         exp_push(1'b1, A_TCR, 8'h80);
         exp_push(1'b1, A_TCR, 8'h10);
      end
      exp_push(1'b1, A_TCR, 8'h00);
      stop_at = 16;
      start_cmd("periodic", 8'h79, 1'b0, 2'b00, 1'b1);
      wait_idle("periodic");
      check_log("periodic");
      check_evt("periodic", 3, 1'b0);

      // stop_req raised while waiting between polls.
      prepare(0);
      tsr_q.push_back(8'h00);
      exp_push(1'b0, A_TSR, 8'h00);
      exp_push(1'b1, A_TDR, 8'h5A);
      exp_push(1'b1, A_TCR, 8'h80);
      exp_push(1'b1, A_TCR, 8'h11);
      exp_push(1'b1, A_TCR, 8'h00);
      stop_at = 4; stop_dly = 6;
      start_cmd("stop_gap", 8'h5A, 1'b0, 2'b01, 1'b0);
      wait_idle("stop_gap");
      check_log("stop_gap");
      check_evt("stop_gap", 0, 1'b0);

      // Bus error on the TDR write, then a clean command clears err.
      prepare(0);
      tsr_q.push_back(8'h00);
      exp_push(1'b0, A_TSR, 8'h00);
      exp_push(1'b1, A_TDR, 8'h64);
      exp_push(1'b1, A_TCR, 8'h00);
      err_at = 1;
      start_cmd("slverr", 8'h64, 1'b1, 2'b10, 1'b1);
      wait_idle("slverr");
      check_log("slverr");
      check_evt("slverr", 0, 1'b0);
      chk("slverr err set", err, 1'b1);
      repeat (5) @(negedge pclk);
      chk("slverr err sticky", err, 1'b1);
      prepare(0);
      quiet_q.delete();
      setup_oneshot(8'h20, 8'h30, 8'h00, 8'h02);
      start_cmd("err_clr", 8'h20, 1'b1, 2'b00, 1'b0);
      chk("err_clr after accept", err, 1'b0);
      wait_idle("err_clr");
      check_log("err_clr");
      chk("err_clr err", err, 1'b0);

      // Randomized one-shot runs against the sequence model.
      for (int k = 0; k < 8; k++) begin
         logic [7:0] rl, st, ev, uf, ef;
         bit         dn;
         logic [1:0] ck;
         int         nq;
         rl = 8'($urandom_range(0, 255));
         dn = 1'($urandom_range(0, 1));
         ck = 2'($urandom_range(0, 3));
         uf = dn ? 8'h01 : 8'h02;
         ef = dn ? 8'h02 : 8'h01;
         st = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 3)) : 8'h00;
         ev = ef | (($urandom_range(0, 1) == 1) ? uf : 8'h00);
         nq = $urandom_range(0, 3);
         prepare($urandom_range(0, 3));
         quiet_q.delete();
         for (int q = 0; q < nq; q++) quiet_q.push_back(($urandom_range(0, 1) == 1) ? uf : 8'h00);
         setup_oneshot(rl, 8'((dn ? 32 : 0) + 16 + int'(ck)), st, ev);
         start_cmd($sformatf("rnd%0d", k), rl, dn, ck, 1'b0);
         wait_idle($sformatf("rnd%0d", k));
         check_log($sformatf("rnd%0d", k));
         check_evt($sformatf("rnd%0d", k), 1, dn);
      end

      // Reset in the middle of a wait-stated transfer: bus drops, no HALT write.
      prepare(3);
      tsr_q.push_back(8'h00);
      start_cmd("midrst", 8'h11, 1'b0, 2'b00, 1'b0);
      begin
         int t;
         t = 0;
         while (!(bus.psel && bus.penable) && t < 100) begin @(negedge pclk); t++; end
      end
      chk("midrst in access", {bus.psel, bus.penable}, 2'b11);
      preset = 1'b1;
      @(negedge pclk);
      chk("midrst bus idle", {bus.psel, bus.penable}, 2'b00);
      chk("midrst cmd_ready", cmd_ready, 1'b1);
      chk("midrst busy", busy, 1'b0);
      preset = 1'b0;
      repeat (30) @(negedge pclk);
      chk("midrst no xfer", log_q.size(), 0);
      chk("midrst still idle", bus.psel, 1'b0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
